csa_accum_ctrl: RTL and testbench

CSA_ACCUM_CTRL -- requirements
Module: csa_accum_ctrl

---
 rtl/csa_accum_ctrl.sv | 160 ++++++++++++++++
 tb/tb_csa_accum_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/csa_accum_ctrl.sv
// csa_accum_ctrl: packet accumulator built on a carry-save adder.
// Operands are folded into a redundant (S, C) pair with no carry propagation;
// the single carry-propagate add happens once per packet in RESOLVE.
// Optional feature: define CSA_ACCUM_CNT_EN to add the out_count port
// (number of operands in the reported packet).
module csa_accum_ctrl #(
    parameter int IN_W    = 4,
    parameter int ACC_W   = 8,
    parameter int MAX_OPS = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [IN_W-1:0]                   in_data,
    input  logic                              in_valid,
    input  logic                              in_last,
    output logic                              in_ready,
    input  logic                              clr,
    output logic [ACC_W-1:0]                  out_data,
    output logic                              out_trunc,
    output logic                              out_valid,
    input  logic                              out_ready
`ifdef CSA_ACCUM_CNT_EN
    ,
    output logic [$clog2(MAX_OPS+1)-1:0]      out_count
`endif
);

    localparam int CNT_W = $clog2(MAX_OPS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_OPS - 1);

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [ACC_W-1:0]   s_reg;
    logic [ACC_W-1:0]   c_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [ACC_W-1:0]   out_data_reg;
    logic               out_trunc_reg;
    logic [CNT_W-1:0]   out_count_reg;

    logic [ACC_W-1:0]   x_ext;
    logic [ACC_W-1:0]   s_next;
    logic [ACC_W-1:0]   c_next;
    logic               xfer;
    logic               pkt_end;

    // Zero-extend the operand to accumulator width (works for ACC_W == IN_W too)
    always_comb begin
        x_ext            = '0;
        x_ext[IN_W-1:0]  = in_data;
    end

    // Carry-save bit cells: sum stays in place, majority carry moves up one bit
    assign c_next[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < ACC_W; gi++) begin : g_csa
            assign s_next[gi] = s_reg[gi] ^ c_reg[gi] ^ x_ext[gi];
            if (gi < ACC_W - 1) begin : g_carry
                assign c_next[gi+1] = (s_reg[gi] & c_reg[gi]) |
                                      (s_reg[gi] & x_ext[gi]) |
                                      (c_reg[gi] & x_ext[gi]);
            end
        end
    endgenerate

    assign in_ready = (state_reg == ACCUM);
    assign out_valid = (state_reg == OUTPUT);
    assign xfer     = in_valid & in_ready;
    assign pkt_end  = in_last | (cnt_reg == CNT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ACCUM;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; clr overrides every other transition
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ACCUM:   if (xfer && pkt_end) state_next = RESOLVE;
            RESOLVE: state_next = OUTPUT;
            OUTPUT:  if (out_ready) state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
        if (clr) begin
            state_next = ACCUM;
        end
    end

    // Datapath: carry-save accumulate, resolve once, clear on handshake or clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_reg         <= '0;
            c_reg         <= '0;
            cnt_reg       <= '0;
            out_data_reg  <= '0;
            out_trunc_reg <= 1'b0;
            out_count_reg <= '0;
        end else if (clr) begin
            s_reg         <= '0;
            c_reg         <= '0;
            cnt_reg       <= '0;
            out_data_reg  <= '0;
            out_trunc_reg <= 1'b0;
            out_count_reg <= '0;
        end else begin
            case (state_reg)
                ACCUM: begin
                    if (xfer) begin
                        s_reg   <= s_next;
                        c_reg   <= c_next;
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        // Hitting the operand limit without in_last marks truncation
                        if ((cnt_reg == CNT_LAST) && !in_last) begin
                            out_trunc_reg <= 1'b1;
                        end
                    end
                end
                RESOLVE: begin
                    out_data_reg  <= s_reg + c_reg;
                    out_count_reg <= cnt_reg;
                end
                OUTPUT: begin
                    if (out_ready) begin
                        s_reg         <= '0;
                        c_reg         <= '0;
                        cnt_reg       <= '0;
                        out_trunc_reg <= 1'b0;
                    end
                end
                default: begin
                    s_reg   <= '0;
                    c_reg   <= '0;
                    cnt_reg <= '0;
                end
            endcase
        end
    end

    assign out_data  = out_data_reg;
    assign out_trunc = out_trunc_reg;

`ifdef CSA_ACCUM_CNT_EN
    assign out_count = out_count_reg;
`else
    // Count is still tracked so both builds share one datapath
    logic unused_count;
    assign unused_count = ^out_count_reg;
`endif

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Testbench for csa_accum_ctrl: table-driven packets, hand-written corner
// sequences (truncation, output stall, reset and clr aborts), and random
// packets checked against a plain-arithmetic sum model.
module tb_csa_accum_ctrl;

    localparam int IN_W    = 8;
    localparam int ACC_W   = 8;
    localparam int MAX_OPS = 16;
    localparam int CNT_W   = $clog2(MAX_OPS + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic             clr;
    logic [ACC_W-1:0] out_data;
    logic             out_trunc;
    logic             out_valid;
    logic             out_ready;
`ifdef CSA_ACCUM_CNT_EN
    logic [CNT_W-1:0] out_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [IN_W-1:0] pkt_ops [0:MAX_OPS-1];

    typedef struct {
        int              len;
        logic [3:0][7:0] ops;
        logic [7:0]      exp_data;
        logic            exp_trunc;
        int              stall;
    } vec_t;

    vec_t vecs [0:5];

    csa_accum_ctrl #(
        .IN_W    (IN_W),
        .ACC_W   (ACC_W),
        .MAX_OPS (MAX_OPS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .clr       (clr),
        .out_data  (out_data),
        .out_trunc (out_trunc),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef CSA_ACCUM_CNT_EN
        ,
        .out_count (out_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%0d expected=%0d", tag, name, act, exp);
        end
    endtask

    // Send pkt_ops[0..len-1], then check resolve timing, stall hold and handshake
    task automatic run_packet(input string tag, input int len, input bit use_last,
                              input int gap_max, input int stall,
                              input logic [ACC_W-1:0] exp_data, input logic exp_trunc);
        int gaps;
        for (int i = 0; i < len; i++) begin
            gaps = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            repeat (gaps) step();
            chk(tag, "in_ready_accum", in_ready, 1);
            in_valid = 1'b1;
            in_data  = pkt_ops[i];
            in_last  = use_last && (i == len - 1);
            step();
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
        chk(tag, "resolve_out_valid", out_valid, 0);
        chk(tag, "resolve_in_ready", in_ready, 0);
        step();
        chk(tag, "latency_out_valid", out_valid, 1);
        chk(tag, "out_data", out_data, exp_data);
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            in_data  = IN_W'($urandom);
            in_last  = 1'(($urandom_range(0, 1)));
            step();
            chk(tag, "stall_out_valid", out_valid, 1);
            chk(tag, "stall_out_data", out_data, exp_data);
            chk(tag, "stall_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk(tag, "out_trunc", out_trunc, exp_trunc);
`ifdef CSA_ACCUM_CNT_EN
        chk(tag, "out_count", out_count, len);
`endif
        $display("pkt %s len=%0d last=%0d out_data=%0d out_trunc=%0d (exp %0d/%0d)",
                 tag, len, use_last, out_data, out_trunc, exp_data, exp_trunc);
        // Handshake edge with a junk operand that must be ignored
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = IN_W'($urandom);
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk(tag, "post_hs_out_valid", out_valid, 0);
        chk(tag, "post_hs_in_ready", in_ready, 1);
    endtask

    // Push operands without in_last (used to build a partial packet)
    task automatic push_partial(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b);
        in_valid = 1'b1; in_last = 1'b0;
        in_data = a; step();
        in_data = b; step();
        in_valid = 1'b0;
    endtask

    initial begin
        int len;
        int sum;
        bit use_last;

        vecs[0] = '{3, {8'd0,   8'd7,   8'd5,   8'd3},   8'd15, 1'b0, 0};
        vecs[1] = '{2, {8'd0,   8'd0,   8'd100, 8'd200}, 8'd44, 1'b0, 5};
        vecs[2] = '{1, {8'd0,   8'd0,   8'd0,   8'd9},   8'd9,  1'b0, 0};
        vecs[3] = '{2, {8'd0,   8'd0,   8'd1,   8'd255}, 8'd0,  1'b0, 1};
        vecs[4] = '{4, {8'd15,  8'd15,  8'd15,  8'd15},  8'd60, 1'b0, 2};
        vecs[5] = '{3, {8'd0,   8'd64,  8'd128, 8'd128}, 8'd64, 1'b0, 0};

        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
        clr = 1'b0; out_ready = 1'b0;
        #1;
        chk("reset", "in_ready", in_ready, 1);
        chk("reset", "out_valid", out_valid, 0);
        chk("reset", "out_data", out_data, 0);
        chk("reset", "out_trunc", out_trunc, 0);
        step(); step();
        rst_n = 1'b1;
        step();
        chk("reset", "in_ready_after", in_ready, 1);

        // Table-driven packets
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < vecs[v].len; i++) pkt_ops[i] = vecs[v].ops[i];
            run_packet($sformatf("vec%0d", v), vecs[v].len, 1'b1, 0, vecs[v].stall,
                       vecs[v].exp_data, vecs[v].exp_trunc);
        end

        // Operand limit: 16 x 15 with no in_last
        for (int i = 0; i < MAX_OPS; i++) pkt_ops[i] = 8'd15;
        run_packet("trunc", MAX_OPS, 1'b0, 0, 3, 8'd240, 1'b1);
        pkt_ops[0] = 8'd11;
        run_packet("after_trunc", 1, 1'b1, 0, 0, 8'd11, 1'b0);

        // Reset mid-packet discards the partial sum and clears outputs
        push_partial(8'd4, 8'd6);
        rst_n = 1'b0;
        #1;
        chk("rst_mid", "out_data", out_data, 0);
        chk("rst_mid", "out_valid", out_valid, 0);
        chk("rst_mid", "in_ready", in_ready, 1);
        step();
        rst_n = 1'b1;
        step();
        pkt_ops[0] = 8'd1; pkt_ops[1] = 8'd2;
        run_packet("rst_next", 2, 1'b1, 0, 0, 8'd3, 1'b0);

        // clr wins over a simultaneous (last) transfer
        push_partial(8'd4, 8'd6);
        clr = 1'b1; in_valid = 1'b1; in_data = 8'd9; in_last = 1'b1;
        step();
        clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        chk("clr_mid", "out_data", out_data, 0);
        chk("clr_mid", "out_valid", out_valid, 0);
        chk("clr_mid", "in_ready", in_ready, 1);
        chk("clr_mid", "out_trunc", out_trunc, 0);
`ifdef CSA_ACCUM_CNT_EN
        chk("clr_mid", "out_count", out_count, 0);
`endif
        pkt_ops[0] = 8'd1; pkt_ops[1] = 8'd2;
        run_packet("clr_next", 2, 1'b1, 0, 0, 8'd3, 1'b0);

        // Random packets against a plain modular-sum model
        for (int p = 0; p < 30; p++) begin
            len = $urandom_range(1, MAX_OPS);
            use_last = (len < MAX_OPS) ? 1'b1 : 1'(($urandom_range(0, 1)));
            sum = 0;
            for (int i = 0; i < len; i++) begin
                pkt_ops[i] = IN_W'($urandom);
                sum += int'(pkt_ops[i]);
            end
            run_packet($sformatf("rnd%0d", p), len, use_last, 2,
                       $urandom_range(0, 3), ACC_W'(sum % 256), !use_last);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
